// File: rtl/quad_abs_sum_seq.sv
// quad_abs_sum_seq: collects four signed 4-bit samples (A..D), emits |A+B+C+D|
// with an overflow flag through a valid/ready output held until accepted.
// Ports: clk, rst_n (sync, active-low), clear (sync abort),
//        in_valid/in_data/in_ready (sample input), out_valid/out_ready/out_s/out_ovf
//        (result), sample_idx (next slot), grp_cnt (accepted results, wraps).
// Config: define QUAD_ABS_SAT_EN to saturate out_s to 4'hF on overflow (else 4'h0).
module quad_abs_sum_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       in_valid,
    input  logic [3:0] in_data,
    output logic       in_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_s,
    output logic       out_ovf,
    output logic [1:0] sample_idx,
    output logic [7:0] grp_cnt
);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

`ifdef QUAD_ABS_SAT_EN
    localparam logic [3:0] OVF_VAL = 4'hF;
`else
    localparam logic [3:0] OVF_VAL = 4'h0;
`endif

    state_t     state;
    logic [3:0] slot_a;
    logic [3:0] slot_b;
    logic [3:0] slot_c;
    logic [5:0] sum;
    logic [5:0] abs6;
    logic [6:0] mag;
    logic [3:0] res_s;
    logic       res_ovf;

    // Held low during reset so nothing is offered before release.
    assign in_ready = rst_n && (state == COLLECT);

    // Sample D is used straight from the input so the result registers
    // on the same edge that accepts D.
    always_comb begin
        sum = {{2{slot_a[3]}}, slot_a}
            + {{2{slot_b[3]}}, slot_b}
            + {{2{slot_c[3]}}, slot_c}
            + {{2{in_data[3]}}, in_data};
        // -32 negates to 6'b100000, which is 32 read as unsigned.
        abs6    = sum[5] ? (~sum + 6'd1) : sum;
        mag     = {1'b0, abs6};
        res_ovf = (mag > 7'd15);
        res_s   = res_ovf ? OVF_VAL : mag[3:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= COLLECT;
            sample_idx <= 2'd0;
            slot_a     <= 4'd0;
            slot_b     <= 4'd0;
            slot_c     <= 4'd0;
            out_valid  <= 1'b0;
            out_s      <= 4'd0;
            out_ovf    <= 1'b0;
            grp_cnt    <= 8'd0;
        end else if (clear) begin
            state      <= COLLECT;
            sample_idx <= 2'd0;
            slot_a     <= 4'd0;
            slot_b     <= 4'd0;
            slot_c     <= 4'd0;
            out_valid  <= 1'b0;
            out_s      <= 4'd0;
            out_ovf    <= 1'b0;
        end else begin
            unique case (state)
                COLLECT: begin
                    if (in_valid) begin
                        sample_idx <= sample_idx + 2'd1;
                        unique case (sample_idx)
                            2'd0: slot_a <= in_data;
                            2'd1: slot_b <= in_data;
                            2'd2: slot_c <= in_data;
                            2'd3: begin
                                state     <= HOLD;
                                out_valid <= 1'b1;
                                out_s     <= res_s;
                                out_ovf   <= res_ovf;
                            end
                        endcase
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= COLLECT;
                        out_valid <= 1'b0;
                        out_s     <= 4'd0;
                        out_ovf   <= 1'b0;
                        grp_cnt   <= grp_cnt + 8'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_quad_abs_sum_seq.sv
// tb_quad_abs_sum_seq: directed self-checking bench for quad_abs_sum_seq.
// Inputs change 1ns after each rising edge; outputs are sampled there too.
module tb_quad_abs_sum_seq;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_s;
    logic       out_ovf;
    logic [1:0] sample_idx;
    logic [7:0] grp_cnt;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_grp = 8'd0;

`ifdef QUAD_ABS_SAT_EN
    localparam logic [3:0] OVF_S = 4'hF;
`else
    localparam logic [3:0] OVF_S = 4'h0;
`endif

    quad_abs_sum_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_s      (out_s),
        .out_ovf    (out_ovf),
        .sample_idx (sample_idx),
        .grp_cnt    (grp_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic v, input logic [3:0] d,
                        input logic ordy, input logic clr);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        clear     = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        in_data   = 4'd0;
        out_ready = 1'b0;
        clear     = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        step(1'b1, 4'd5, 1'b1, 1'b0);
        step(1'b1, 4'd5, 1'b1, 1'b0);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %0b exp 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0b exp 0", out_valid); end
        checks++; if (out_s !== 4'd0 || out_ovf !== 1'b0) begin errors++; $display("FAIL rst_out got s=%0d ovf=%0b exp 0/0", out_s, out_ovf); end
        checks++; if (sample_idx !== 2'd0) begin errors++; $display("FAIL rst_idx got %0d exp 0", sample_idx); end
        checks++; if (grp_cnt !== 8'd0) begin errors++; $display("FAIL rst_grp got %0d exp 0", grp_cnt); end
        rst_n = 1'b1;
        idle();
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rel_in_ready got %0b exp 1", in_ready); end
        exp_grp = 8'd0;
    endtask

    // 3 + 2 - 1 + 4 = 8
    task automatic test_basic();
        step(1'b1, 4'd3, 1'b0, 1'b0);
        checks++; if (sample_idx !== 2'd1) begin errors++; $display("FAIL basic_idx1 got %0d exp 1", sample_idx); end
        step(1'b1, 4'd2, 1'b0, 1'b0);
        step(1'b0, 4'd7, 1'b0, 1'b0);
        checks++; if (sample_idx !== 2'd2 || out_valid !== 1'b0) begin errors++; $display("FAIL basic_gap got idx=%0d ov=%0b exp 2/0", sample_idx, out_valid); end
        step(1'b1, 4'hF, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early got %0b exp 0", out_valid); end
        step(1'b1, 4'd4, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b1 || out_s !== 4'd8 || out_ovf !== 1'b0) begin errors++; $display("FAIL basic_res got v=%0b s=%0d ovf=%0b exp 1/8/0", out_valid, out_s, out_ovf); end
        checks++; if (sample_idx !== 2'd0 || in_ready !== 1'b0) begin errors++; $display("FAIL basic_hold got idx=%0d rdy=%0b exp 0/0", sample_idx, in_ready); end
        step(1'b0, 4'd0, 1'b1, 1'b0);
        exp_grp = exp_grp + 8'd1;
        checks++; if (out_valid !== 1'b0 || out_s !== 4'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL basic_rel got v=%0b s=%0d rdy=%0b exp 0/0/1", out_valid, out_s, in_ready); end
        checks++; if (grp_cnt !== exp_grp) begin errors++; $display("FAIL basic_grp got %0d exp %0d", grp_cnt, exp_grp); end
    endtask

    task automatic group(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d);
        step(1'b1, a, 1'b0, 1'b0);
        step(1'b1, b, 1'b0, 1'b0);
        step(1'b1, c, 1'b0, 1'b0);
        step(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic test_ovf();
        // -8 * 4 = -32 -> magnitude 32
        group(4'h8, 4'h8, 4'h8, 4'h8);
        checks++; if (out_valid !== 1'b1 || out_ovf !== 1'b1 || out_s !== OVF_S) begin errors++; $display("FAIL ovf_m32 got v=%0b ovf=%0b s=%0d exp 1/1/%0d", out_valid, out_ovf, out_s, OVF_S); end
        step(1'b0, 4'd0, 1'b1, 1'b0);
        exp_grp = exp_grp + 8'd1;
        // 7+7+1+0 = 15, largest non-overflow
        group(4'd7, 4'd7, 4'd1, 4'd0);
        checks++; if (out_ovf !== 1'b0 || out_s !== 4'd15) begin errors++; $display("FAIL ovf_15 got ovf=%0b s=%0d exp 0/15", out_ovf, out_s); end
        step(1'b0, 4'd0, 1'b1, 1'b0);
        exp_grp = exp_grp + 8'd1;
        // 7+7+2+0 = 16, smallest overflow
        group(4'd7, 4'd7, 4'd2, 4'd0);
        checks++; if (out_ovf !== 1'b1 || out_s !== OVF_S) begin errors++; $display("FAIL ovf_16 got ovf=%0b s=%0d exp 1/%0d", out_ovf, out_s, OVF_S); end
        step(1'b0, 4'd0, 1'b1, 1'b0);
        exp_grp = exp_grp + 8'd1;
        // -3 * 4 = -12 -> 12
        group(4'hD, 4'hD, 4'hD, 4'hD);
        checks++; if (out_ovf !== 1'b0 || out_s !== 4'd12) begin errors++; $display("FAIL ovf_m12 got ovf=%0b s=%0d exp 0/12", out_ovf, out_s); end
        step(1'b0, 4'd0, 1'b1, 1'b0);
        exp_grp = exp_grp + 8'd1;
        // -8 - 8 + 0 + 0 = -16 -> overflow on the negative side
        group(4'h8, 4'h8, 4'h0, 4'h0);
        checks++; if (out_ovf !== 1'b1 || out_s !== OVF_S) begin errors++; $display("FAIL ovf_m16 got ovf=%0b s=%0d exp 1/%0d", out_ovf, out_s, OVF_S); end
        step(1'b0, 4'd0, 1'b1, 1'b0);
        exp_grp = exp_grp + 8'd1;
        checks++; if (grp_cnt !== exp_grp) begin errors++; $display("FAIL ovf_grp got %0d exp %0d", grp_cnt, exp_grp); end
    endtask

    // 1+2+3+4 = 10, held with in_valid asserted
    task automatic test_back_pressure();
        group(4'd1, 4'd2, 4'd3, 4'd4);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 4'd7, 1'b0, 1'b0);
            checks++;
            if (out_valid !== 1'b1 || out_s !== 4'd10 || in_ready !== 1'b0 || sample_idx !== 2'd0) begin
                errors++;
                $display("FAIL bp_hold%0d got v=%0b s=%0d rdy=%0b idx=%0d exp 1/10/0/0", i, out_valid, out_s, in_ready, sample_idx);
            end
        end
        step(1'b1, 4'd7, 1'b1, 1'b0);
        exp_grp = exp_grp + 8'd1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || sample_idx !== 2'd0) begin errors++; $display("FAIL bp_rel got v=%0b rdy=%0b idx=%0d exp 0/1/0", out_valid, in_ready, sample_idx); end
        checks++; if (grp_cnt !== exp_grp) begin errors++; $display("FAIL bp_grp got %0d exp %0d", grp_cnt, exp_grp); end
    endtask

    task automatic test_clear();
        step(1'b1, 4'd5, 1'b0, 1'b0);
        step(1'b1, 4'd5, 1'b0, 1'b0);
        step(1'b1, 4'd5, 1'b0, 1'b1);
        checks++; if (sample_idx !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL clr_idx got idx=%0d v=%0b exp 0/0", sample_idx, out_valid); end
        group(4'd1, 4'd1, 4'd1, 4'd1);
        checks++; if (out_valid !== 1'b1 || out_s !== 4'd4 || out_ovf !== 1'b0) begin errors++; $display("FAIL clr_res got v=%0b s=%0d ovf=%0b exp 1/4/0", out_valid, out_s, out_ovf); end
        // clear beats a same-cycle output handshake
        step(1'b0, 4'd0, 1'b1, 1'b1);
        checks++; if (out_valid !== 1'b0 || out_s !== 4'd0 || grp_cnt !== exp_grp) begin errors++; $display("FAIL clr_hs got v=%0b s=%0d grp=%0d exp 0/0/%0d", out_valid, out_s, grp_cnt, exp_grp); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL clr_rdy got %0b exp 1", in_ready); end
    endtask

    task automatic test_reset_hold();
        group(4'd2, 4'd2, 4'd2, 4'd2);
        checks++; if (out_valid !== 1'b1 || out_s !== 4'd8) begin errors++; $display("FAIL rh_pre got v=%0b s=%0d exp 1/8", out_valid, out_s); end
        rst_n = 1'b0;
        step(1'b1, 4'd3, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b0 || grp_cnt !== 8'd0 || in_ready !== 1'b0) begin errors++; $display("FAIL rh_rst got v=%0b grp=%0d rdy=%0b exp 0/0/0", out_valid, grp_cnt, in_ready); end
        rst_n = 1'b1;
        exp_grp = 8'd0;
        idle();
        step(1'b0, 4'd0, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b0 || grp_cnt !== 8'd0 || sample_idx !== 2'd0) begin errors++; $display("FAIL rh_post got v=%0b grp=%0d idx=%0d exp 0/0/0", out_valid, grp_cnt, sample_idx); end
    endtask

    task automatic test_wrap();
        for (int g = 0; g < 256; g++) begin
            group(4'd0, 4'd0, 4'd0, 4'd1);
            step(1'b0, 4'd0, 1'b1, 1'b0);
            exp_grp = exp_grp + 8'd1;
            if (g == 254) begin
                checks++; if (grp_cnt !== 8'd255) begin errors++; $display("FAIL wrap_255 got %0d exp 255", grp_cnt); end
            end
        end
        checks++; if (grp_cnt !== 8'd0 || grp_cnt !== exp_grp) begin errors++; $display("FAIL wrap_0 got %0d exp 0", grp_cnt); end
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        test_reset();
        test_basic();
        test_ovf();
        test_back_pressure();
        test_clear();
        test_reset_hold();
        test_wrap();
        idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/quad_abs_sum_seq.md
QUAD_ABS_SUM_SEQ -- requirements
Module: quad_abs_sum_seq

Interface
REQ-001 Ports SHALL be as listed: name, direction, width, meaning; clock and reset first.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 clear  input  1  synchronous abort; discards partial group and pending result.
REQ-005 in_valid  input  1  in_data holds a sample.
REQ-006 in_data  input  4  signed two's-complement sample, range -8..7.
REQ-007 in_ready  output  1  block accepts a sample this cycle.
REQ-008 out_valid  output  1  out_s/out_ovf hold a result.
REQ-009 out_ready  input  1  downstream accepts the result.
REQ-010 out_s  output  4  unsigned magnitude |A+B+C+D|.
REQ-011 out_ovf  output  1  magnitude exceeded 15.
REQ-012 sample_idx  output  2  index of the next sample slot, 0..3.
REQ-013 grp_cnt  output  8  count of results accepted downstream; wraps 255->0.

Function
REQ-014 A sample SHALL be accepted only in a cycle with in_valid=1 and in_ready=1.
REQ-015 The FSM SHALL have two states: COLLECT (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-016 In COLLECT, each accepted sample SHALL be stored in slot sample_idx (A=0, B=1, C=2, D=3), and sample_idx SHALL increment.
REQ-017 Acceptance at sample_idx=3 SHALL move the FSM to HOLD, wrap sample_idx to 0 and register the result; out_valid SHALL be 1 on the following cycle (latency 1 cycle after D).
REQ-018 The sum SHALL be computed sign-extended to 6 bits (range -32..28), and the magnitude to 7 bits (range 0..32); no intermediate truncation.
REQ-019 Magnitude <=15: out_s = magnitude, out_ovf=0.
REQ-020 Magnitude >=16: out_ovf=1, and out_s SHALL follow REQ-033.
REQ-021 In HOLD, out_s/out_ovf SHALL stay stable until out_ready=1; that handshake returns the FSM to COLLECT next cycle and increments grp_cnt.
REQ-022 in_valid SHALL be ignored in HOLD; no sample is consumed.
REQ-023 in_valid=0 in COLLECT SHALL hold sample_idx and the stored slots unchanged; gaps are unlimited.
REQ-024 clear=1 SHALL force COLLECT, sample_idx=0, out_valid=0 next cycle; a sample presented in the same cycle SHALL be discarded; grp_cnt SHALL be unchanged.
REQ-025 clear and an out handshake in the same cycle: clear SHALL win, and grp_cnt SHALL NOT increment.
REQ-026 out_s/out_ovf SHALL read 0 whenever out_valid=0.

Reset
REQ-027 rst_n=0 at a rising clk edge SHALL set state=COLLECT, sample_idx=0, slots=0, out_valid=0, out_s=0, out_ovf=0, grp_cnt=0.
REQ-028 in_ready SHALL be 0 while rst_n=0 and SHALL be 1 on the first cycle after release.
REQ-029 Reset SHALL take priority over clear and all handshakes.
REQ-030 Reset asserted mid-group or in HOLD SHALL discard all partial or pending data without emitting a result.

Configuration
REQ-031 The macro QUAD_ABS_SAT_EN SHALL select the overflow output value.
REQ-032 With QUAD_ABS_SAT_EN defined: overflow gives out_s=4'hF (saturation).
REQ-033 Without QUAD_ABS_SAT_EN: overflow gives out_s=4'h0; out_ovf=1 in both builds.

Verification
REQ-034 Samples 3,2,-1,4, back-to-back -> one cycle after D: out_valid=1, out_s=8, out_ovf=0, sample_idx=0.
REQ-035 Samples -8,-8,-8,-8 -> out_ovf=1; out_s=15 with QUAD_ABS_SAT_EN, 0 without; samples 7,7,1,0 -> out_s=15, out_ovf=0.
REQ-036 Result pending with out_ready=0 for 5 cycles, in_valid=1 throughout -> out_s stable, in_ready=0, no sample consumed; out_ready=1 -> grp_cnt+1, in_ready=1 next cycle.
REQ-037 Two samples accepted, then clear=1 with in_valid=1 -> sample_idx=0, no result; next four samples 1,1,1,1 -> out_s=4.
REQ-038 rst_n=0 while in HOLD -> out_valid=0, grp_cnt=0; 256 accepted groups -> grp_cnt wraps to 0.
